// File: rtl/writeback_stage_buffered_if.sv
// ============================================================================
// Module : writeback_stage_buffered_if
// Brief  : MEM-side, regfile-side and forwarding signals of the writeback stage
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface writeback_stage_buffered_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 64,
  parameter int OFF_W          = $clog2(BUS_DATA_WIDTH/8)
);
  logic                      inValid;
  logic                      outReady;
  logic [1:0]                inResultSel;
  logic [1:0]                inLoadSize;
  logic                      inLoadUnsigned;
  logic [OFF_W-1:0]          inByteOffset;
  logic [BUS_DATA_WIDTH-1:0] inReadData;
  logic [BUS_DATA_WIDTH-1:0] inALUData;
  logic [PC_WIDTH-1:0]       inPC;
  logic                      inRegWrite;
  logic [REG_ADDR_WIDTH-1:0] inDestReg;
  logic                      inRfReady;
  logic                      outRegWrite;
  logic [REG_ADDR_WIDTH-1:0] outDestReg;
  logic [BUS_DATA_WIDTH-1:0] outWriteData;
  logic                      outFwdValid;
  logic [REG_ADDR_WIDTH-1:0] outFwdReg;
  logic [BUS_DATA_WIDTH-1:0] outFwdData;
  logic [63:0]               outRetireCount;

  // Master is the surrounding pipeline (MEM stage plus regfile port)
  modport master (
    output inValid, inResultSel, inLoadSize, inLoadUnsigned, inByteOffset,
           inReadData, inALUData, inPC, inRegWrite, inDestReg, inRfReady,
    input  outReady, outRegWrite, outDestReg, outWriteData,
           outFwdValid, outFwdReg, outFwdData, outRetireCount
  );

  modport slave (
    input  inValid, inResultSel, inLoadSize, inLoadUnsigned, inByteOffset,
           inReadData, inALUData, inPC, inRegWrite, inDestReg, inRfReady,
    output outReady, outRegWrite, outDestReg, outWriteData,
           outFwdValid, outFwdReg, outFwdData, outRetireCount
  );
endinterface

`default_nettype wire

// File: rtl/writeback_stage_buffered.sv
// ============================================================================
// Module : writeback_stage_buffered
// Brief  : Writeback stage - result select, load alignment, 2-entry FIFO
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_stage_buffered #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 64
) (
  input  logic clk,
  input  logic reset_n,
  writeback_stage_buffered_if.slave bus
);
  localparam int   OFF_W = $clog2(BUS_DATA_WIDTH/8);
  localparam logic IS32  = (BUS_DATA_WIDTH == 32);

  // ---------------- result formatting ----------------
  logic [BUS_DATA_WIDTH-1:0] shifted;
  logic [63:0]               s64;
  logic [63:0]               load64;
  logic                      sx;
  logic [PC_WIDTH-1:0]       pc4;
  logic [BUS_DATA_WIDTH-1:0] fmt_data;
  logic                      fmt_wflag;

  assign shifted = bus.inReadData >> {bus.inByteOffset, 3'b000};
  assign s64     = 64'(shifted);
  assign sx      = ~bus.inLoadUnsigned;
  assign pc4     = bus.inPC + PC_WIDTH'(4);

  // Extension is done in a 64-bit domain so a 32-bit bus needs no special slicing
  always_comb begin
    load64 = s64;
    case (bus.inLoadSize)
      2'b00:   load64 = {{56{sx & s64[7]}},  s64[7:0]};
      2'b01:   load64 = {{48{sx & s64[15]}}, s64[15:0]};
      2'b10:   load64 = {{32{sx & s64[31]}}, s64[31:0]};
      default: load64 = IS32 ? {{32{sx & s64[31]}}, s64[31:0]} : s64;
    endcase
  end

  always_comb begin
    fmt_data = bus.inALUData;
    case (bus.inResultSel)
      2'b01:   fmt_data = BUS_DATA_WIDTH'(load64);
      2'b10:   fmt_data = BUS_DATA_WIDTH'(pc4);
      default: fmt_data = bus.inALUData;
    endcase
  end

  assign fmt_wflag = bus.inRegWrite && (bus.inDestReg != '0);

  // ---------------- 2-entry FIFO ----------------
  logic [BUS_DATA_WIDTH-1:0] data_q [2];
  logic [REG_ADDR_WIDTH-1:0] dest_q [2];
  logic [1:0]                wflag_q;
  logic                      wr_ptr;
  logic                      rd_ptr;
  logic [1:0]                count;
  logic [63:0]               retire_cnt;
  logic                      head_valid;
  logic                      head_wflag;
  logic                      ready;
  logic                      push;
  logic                      pop;

  assign head_valid = (count != 2'd0);
  assign head_wflag = wflag_q[rd_ptr];
  // Gated by reset_n so the stage never advertises readiness while held in reset
  assign ready      = reset_n && (count != 2'd2);
  assign push       = bus.inValid && ready;
  assign pop        = head_valid && (!head_wflag || bus.inRfReady);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      retire_cnt <= 64'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        retire_cnt <= retire_cnt + 64'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; every read is qualified by head_valid
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr]  <= fmt_data;
      dest_q[wr_ptr]  <= bus.inDestReg;
      wflag_q[wr_ptr] <= fmt_wflag;
    end
  end

  // ---------------- outputs ----------------
  assign bus.outReady       = ready;
  assign bus.outRegWrite    = head_valid && head_wflag;
  assign bus.outDestReg     = head_valid ? dest_q[rd_ptr] : '0;
  assign bus.outWriteData   = head_valid ? data_q[rd_ptr] : '0;
  assign bus.outFwdValid    = head_valid && head_wflag;
  assign bus.outFwdReg      = head_valid ? dest_q[rd_ptr] : '0;
  assign bus.outFwdData     = head_valid ? data_q[rd_ptr] : '0;
  assign bus.outRetireCount = retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage_buffered.sv
// ============================================================================
// Module : tb_writeback_stage_buffered
// Brief  : Self-checking bench: vector table, corner sequences, random traffic
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage_buffered;
  localparam int W = 64;
  localparam int R = 5;
  localparam int P = 64;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  writeback_stage_buffered_if #(.BUS_DATA_WIDTH(W), .REG_ADDR_WIDTH(R), .PC_WIDTH(P)) bus ();

  writeback_stage_buffered #(.BUS_DATA_WIDTH(W), .REG_ADDR_WIDTH(R), .PC_WIDTH(P)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic         we;
    logic [R-1:0] dest;
    logic [W-1:0] data;
  } ent_t;

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  off;
    logic [63:0] rd;
    logic [63:0] alu;
    logic [63:0] pc;
    logic        rw;
    logic [4:0]  dest;
    logic [63:0] exp_data;
    logic        exp_we;
  } vec_t;

  ent_t        q[$];
  logic [63:0] m_cnt;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load result from arithmetic: shift, mask to the field, sign-fill above it
  function automatic logic [63:0] ref_format(input logic [1:0] sel, input logic [1:0] size,
      input logic uns, input logic [2:0] off, input logic [63:0] rd,
      input logic [63:0] alu, input logic [63:0] pc);
    logic [63:0] s, mask, v;
    int nbits;
    if (sel == 2'b10) return pc + 64'd4;
    if (sel != 2'b01) return alu;
    s     = rd >> (8 * off);
    nbits = 8 * (1 << size);
    if (nbits == 64) return s;
    mask = (64'd1 << nbits) - 64'd1;
    v    = s & mask;
    if (!uns && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic check_outputs();
    logic hv;
    hv = (q.size() > 0);
    chk("ready",     bus.outReady,       reset_n && (q.size() < 2));
    chk("regwrite",  bus.outRegWrite,    hv && q[0].we);
    chk("destreg",   bus.outDestReg,     hv ? q[0].dest : '0);
    chk("wdata",     bus.outWriteData,   hv ? q[0].data : '0);
    chk("fwd_valid", bus.outFwdValid,    hv && q[0].we);
    chk("fwd_reg",   bus.outFwdReg,      hv ? q[0].dest : '0);
    chk("fwd_data",  bus.outFwdData,     hv ? q[0].data : '0);
    chk("retire",    bus.outRetireCount, m_cnt);
  endtask

  // Called at a falling edge; drives inputs, advances the model across one rising edge
  task automatic step(input logic v, input logic [1:0] sel, input logic [1:0] size,
      input logic uns, input logic [2:0] off, input logic [63:0] rd, input logic [63:0] alu,
      input logic [63:0] pc, input logic rw, input logic [4:0] dest, input logic rfr);
    logic do_pop, do_push;
    ent_t e;
    bus.inValid = v;         bus.inResultSel = sel;  bus.inLoadSize = size;
    bus.inLoadUnsigned = uns; bus.inByteOffset = off; bus.inReadData = rd;
    bus.inALUData = alu;     bus.inPC = pc;          bus.inRegWrite = rw;
    bus.inDestReg = dest;    bus.inRfReady = rfr;
    do_pop  = (q.size() > 0) && (!q[0].we || rfr);
    do_push = v && (q.size() < 2);
    e.we    = rw && (dest != 0);
    e.dest  = dest;
    e.data  = ref_format(sel, size, uns, off, rd, alu, pc);
    @(posedge clk);
    if (do_pop) begin
      void'(q.pop_front());
      m_cnt++;
    end
    if (do_push) q.push_back(e);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic rfr);
    step(1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0, rfr);
  endtask

  task automatic push_alu(input logic [63:0] d, input logic [4:0] dest, input logic rfr);
    step(1'b1, 2'b00, 2'b00, 1'b0, 3'd0, 64'd0, d, 64'd0, 1'b1, dest, rfr);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{2'b00, 2'b00, 1'b0, 3'd0, 64'h0, 64'h1234, 64'h0, 1'b1, 5'd5, 64'h1234, 1'b1};
    vecs[1]  = '{2'b01, 2'b00, 1'b0, 3'd1, 64'h80FF, 64'h0, 64'h0, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
    vecs[2]  = '{2'b01, 2'b00, 1'b1, 3'd1, 64'h80FF, 64'h0, 64'h0, 1'b1, 5'd6, 64'h80, 1'b1};
    vecs[3]  = '{2'b10, 2'b00, 1'b0, 3'd0, 64'h0, 64'h0, 64'h1000, 1'b1, 5'd3, 64'h1004, 1'b1};
    vecs[4]  = '{2'b11, 2'b00, 1'b0, 3'd0, 64'h0, 64'hDEAD, 64'h40, 1'b1, 5'd7, 64'hDEAD, 1'b1};
    vecs[5]  = '{2'b01, 2'b01, 1'b0, 3'd6, 64'h8001_0000_0000_0000, 64'h0, 64'h0, 1'b1, 5'd8, 64'hFFFF_FFFF_FFFF_8001, 1'b1};
    vecs[6]  = '{2'b01, 2'b10, 1'b1, 3'd4, 64'hF234_5678_0000_0000, 64'h0, 64'h0, 1'b1, 5'd9, 64'hF234_5678, 1'b1};
    vecs[7]  = '{2'b01, 2'b10, 1'b0, 3'd6, 64'h89AB_0000_0000_0000, 64'h0, 64'h0, 1'b1, 5'd10, 64'h89AB, 1'b1};
    vecs[8]  = '{2'b01, 2'b11, 1'b0, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 1'b1, 5'd11, 64'h0123_4567_89AB_CDEF, 1'b1};
    vecs[9]  = '{2'b01, 2'b00, 1'b0, 3'd7, 64'h8000_0000_0000_0000, 64'h0, 64'h0, 1'b1, 5'd12, 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
    vecs[10] = '{2'b00, 2'b00, 1'b0, 3'd0, 64'h0, 64'h55, 64'h0, 1'b0, 5'd5, 64'h55, 1'b0};
    vecs[11] = '{2'b00, 2'b00, 1'b0, 3'd0, 64'h0, 64'h66, 64'h0, 1'b1, 5'd0, 64'h66, 1'b0};
    vecs[12] = '{2'b10, 2'b00, 1'b0, 3'd0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 5'd13, 64'h2, 1'b1};

    // Reset state
    m_cnt   = 64'd0;
    reset_n = 1'b0;
    bus.inValid = 1'b0; bus.inResultSel = '0; bus.inLoadSize = '0; bus.inLoadUnsigned = 1'b0;
    bus.inByteOffset = '0; bus.inReadData = '0; bus.inALUData = '0; bus.inPC = '0;
    bus.inRegWrite = 1'b0; bus.inDestReg = '0; bus.inRfReady = 1'b1;
    #1 check_outputs();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1 check_outputs();
    @(negedge clk);

    // Formatting table: push into an empty FIFO, visible the following cycle
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].sel, vecs[i].size, vecs[i].uns, vecs[i].off, vecs[i].rd,
           vecs[i].alu, vecs[i].pc, vecs[i].rw, vecs[i].dest, 1'b1);
      chk($sformatf("tbl%0d_data", i), bus.outWriteData, vecs[i].exp_data);
      chk($sformatf("tbl%0d_we", i),   bus.outRegWrite,  vecs[i].exp_we);
      idle(1'b1);
      chk($sformatf("tbl%0d_drained", i), bus.outRegWrite, 1'b0);
    end

    // Back-pressure: three pushes with the regfile stalled, then release
    push_alu(64'hA1, 5'd1, 1'b0);
    push_alu(64'hA2, 5'd2, 1'b0);
    chk("full_ready", bus.outReady, 1'b0);
    push_alu(64'hA3, 5'd3, 1'b0);
    chk("stall_hold_dest", bus.outDestReg, 5'd1);
    chk("stall_hold_data", bus.outWriteData, 64'hA1);
    idle(1'b1);
    chk("order_second", bus.outDestReg, 5'd2);
    idle(1'b1);
    chk("order_empty", bus.outRegWrite, 1'b0);

    // Write to x0 retires even with the regfile stalled
    begin
      logic [63:0] c0;
      c0 = bus.outRetireCount;
      step(1'b1, 2'b00, 2'b00, 1'b0, 3'd0, 64'd0, 64'h77, 64'd0, 1'b1, 5'd0, 1'b0);
      chk("x0_no_strobe", bus.outRegWrite, 1'b0);
      idle(1'b0);
      chk("x0_retired", bus.outRetireCount, c0 + 64'd1);
    end

    // Push/pop simultaneously at count 1
    push_alu(64'hB1, 5'd4, 1'b0);
    push_alu(64'hB2, 5'd5, 1'b1);
    chk("pushpop_head", bus.outDestReg, 5'd5);

    // Mid-operation reset with two entries buffered
    idle(1'b1);
    step(1'b1, 2'b10, 2'b00, 1'b0, 3'd0, 64'd0, 64'd0, 64'h1000, 1'b1, 5'd6, 1'b0);
    chk("pc4_head", bus.outWriteData, 64'h1004);
    push_alu(64'hC2, 5'd7, 1'b0);
    bus.inValid = 1'b0;
    #2 reset_n = 1'b0;
    q.delete();
    m_cnt = 64'd0;
    #1 check_outputs();
    chk("rst_count", bus.outRetireCount, 64'd0);
    @(posedge clk); #1;
    chk("rst_no_write", bus.outRegWrite, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_outputs();
    @(negedge clk);

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 7), 2'($urandom), 2'($urandom), 1'($urandom),
           3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
